// File: rtl/square_root_iterative_pkg.sv
// Shared types and elaboration helpers for the iterative square root unit.
package square_root_pkg;

    // Controller states: waiting, iterating, result held.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sqrt_state_e;

    // Width of a counter that must hold 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Operand width must be even so the radicand splits into bit pairs.
    function automatic bit width_legal(input int w);
        return (w >= 2) && ((w % 2) == 0);
    endfunction

endpackage

// File: rtl/square_root_iterative_if.sv
// Handshake and data bundle between the operand source and the root unit.
interface square_root_iterative_if #(
    parameter int WIDTH = 8
);
    import square_root_pkg::*;

    localparam int N = WIDTH / 2;

    logic             start;
    logic [WIDTH-1:0] alpha;
    logic             round_nearest;
    logic             busy;
    logic             valid;
    logic [N:0]       root;
    logic [N:0]       remainder;

    // Requester side: issues operands, observes results.
    modport master (
        output start, alpha, round_nearest,
        input  busy, valid, root, remainder
    );

    // Root unit side.
    modport slave (
        input  start, alpha, round_nearest,
        output busy, valid, root, remainder
    );

endinterface

// File: rtl/square_root_iterative_step.sv
// One restoring digit-by-digit iteration: brings in two radicand bits and
// decides the next root bit.
module square_root_step #(
    parameter int N = 4
) (
    input  logic [N-1:0] root_i,
    input  logic [N+1:0] rem_i,
    input  logic [1:0]   bits_i,
    output logic [N-1:0] root_o,
    output logic [N+1:0] rem_o
);
    import square_root_pkg::*;

    logic [N+1:0] rem_sh_s;
    logic [N+1:0] trial_s;
    logic         ge_s;
    logic [N:0]   root_ext_s;
    logic         unused_s;

    // Shift remainder and try subtracting 4*root+1. The running remainder
    // never exceeds 2*root, so its top two bits are zero before the shift.
    always_comb begin
        rem_sh_s   = {rem_i[N-1:0], bits_i};
        trial_s    = {root_i, 2'b01};
        ge_s       = (rem_sh_s >= trial_s);
        if (ge_s) begin
            rem_o = rem_sh_s - trial_s;
        end else begin
            rem_o = rem_sh_s;
        end
        root_ext_s = {root_i, ge_s};
        root_o     = root_ext_s[N-1:0];
        unused_s   = ^{rem_i[N+1:N], root_ext_s[N]};
    end

endmodule

// File: rtl/square_root_iterative.sv
// Sequential integer square root, one root bit per clock, with optional
// round-to-nearest and a floor-based remainder.
module square_root_iterative #(
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    square_root_iterative_if.slave   bus
);
    import square_root_pkg::*;

    localparam int N  = WIDTH / 2;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    if (!width_legal(WIDTH)) begin : g_bad_width
        $error("square_root_iterative: WIDTH must be even and >= 2");
    end

    sqrt_state_e      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             rnd_q, rnd_d;
    logic [N-1:0]     proot_q, proot_d;
    logic [N+1:0]     prem_q, prem_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [N:0]       root_q, root_d;
    logic [N:0]       rem_q, rem_d;

    logic [N-1:0]     step_root_s;
    logic [N+1:0]     step_rem_s;

    square_root_step #(.N(N)) u_step (
        .root_i (proot_q),
        .rem_i  (prem_q),
        .bits_i (sreg_q[WIDTH-1 -: 2]),
        .root_o (step_root_s),
        .rem_o  (step_rem_s)
    );

    // Next-state logic: accept, iterate, and finalise the rounded result.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        rnd_d   = rnd_q;
        proot_d = proot_q;
        prem_d  = prem_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        root_d  = root_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    sreg_d  = bus.alpha;
                    rnd_d   = bus.round_nearest;
                    proot_d = {N{1'b0}};
                    prem_d  = {(N+2){1'b0}};
                    cnt_d   = {CW{1'b0}};
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            RUN: begin
                sreg_d  = sreg_q << 2;
                proot_d = step_root_s;
                prem_d  = step_rem_s;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    rem_d   = step_rem_s[N:0];
                    // Round up when alpha >= r^2 + r + 1, i.e. rem > r.
                    if (rnd_q && (step_rem_s > {2'b00, step_root_s})) begin
                        root_d = {1'b0, step_root_s} + (N+1)'(1);
                    end else begin
                        root_d = {1'b0, step_root_s};
                    end
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            sreg_q  <= {WIDTH{1'b0}};
            rnd_q   <= 1'b0;
            proot_q <= {N{1'b0}};
            prem_q  <= {(N+2){1'b0}};
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            root_q  <= {(N+1){1'b0}};
            rem_q   <= {(N+1){1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            rnd_q   <= rnd_d;
            proot_q <= proot_d;
            prem_q  <= prem_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.valid     = valid_q;
    assign bus.root      = root_q;
    assign bus.remainder = rem_q;

endmodule

// File: tb/tb_square_root_iterative.sv
// Directed bench for the iterative square root: 8-bit vectors plus a
// sampled 16-bit sweep against an independent search model.
module tb_square_root_iterative;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   prev_root8;

    square_root_iterative_if #(.WIDTH(8))  if8 ();
    square_root_iterative_if #(.WIDTH(16)) if16 ();

    square_root_iterative #(.WIDTH(8)) u8 (
        .clock (clk),
        .reset (rst),
        .bus   (if8.slave)
    );

    square_root_iterative #(.WIDTH(16)) u16 (
        .clock (clk),
        .reset (rst),
        .bus   (if16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Full 8-bit operation with exact latency: accept edge + 4 iteration edges.
    task automatic op8(input logic [7:0] a, input logic rn, input int er, input int erem);
        if8.alpha = a;
        if8.round_nearest = rn;
        if8.start = 1'b1;
        @(posedge clk); #1;
        chk("acc_busy", 32'(if8.busy), 32'd1);
        chk("acc_valid", 32'(if8.valid), 32'd0);
        chk("acc_hold_root", 32'(if8.root), 32'(prev_root8));
        if8.start = 1'b0;
        if8.alpha = 8'hA5;
        if8.round_nearest = ~rn;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("run_busy", 32'(if8.busy), 32'd1);
            chk("run_valid", 32'(if8.valid), 32'd0);
        end
        @(posedge clk); #1;
        chk("done_busy", 32'(if8.busy), 32'd0);
        chk("done_valid", 32'(if8.valid), 32'd1);
        chk("done_root", 32'(if8.root), 32'(er));
        chk("done_rem", 32'(if8.remainder), 32'(erem));
        prev_root8 = er;
    endtask

    // 16-bit operation checked against a linear-search reference.
    task automatic op16(input int a, input logic rn);
        int r;
        int rem;
        int er;
        r = 0;
        while ((r + 1) * (r + 1) <= a) r++;
        rem = a - r * r;
        er = (rn && (rem > r)) ? r + 1 : r;
        if16.alpha = 16'(a);
        if16.round_nearest = rn;
        if16.start = 1'b1;
        @(posedge clk); #1;
        chk("w16_acc_busy", 32'(if16.busy), 32'd1);
        if16.start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
        end
        chk("w16_pre_valid", 32'(if16.valid), 32'd0);
        @(posedge clk); #1;
        chk("w16_valid", 32'(if16.valid), 32'd1);
        chk("w16_root", 32'(if16.root), 32'(er));
        chk("w16_rem", 32'(if16.remainder), 32'(rem));
    endtask

    initial begin
        total = 0;
        bad = 0;
        prev_root8 = 0;
        rst = 1'b1;
        if8.start = 1'b0;
        if8.alpha = 8'd0;
        if8.round_nearest = 1'b0;
        if16.start = 1'b0;
        if16.alpha = 16'd0;
        if16.round_nearest = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_busy", 32'(if8.busy), 32'd0);
        chk("rst_valid", 32'(if8.valid), 32'd0);
        chk("rst_root", 32'(if8.root), 32'd0);
        chk("rst_rem", 32'(if8.remainder), 32'd0);
        rst = 1'b0;

        op8(8'd144, 1'b0, 12, 0);
        op8(8'd255, 1'b0, 15, 30);
        op8(8'd255, 1'b1, 16, 30);
        op8(8'd0,   1'b0, 0, 0);
        op8(8'd20,  1'b1, 4, 4);
        op8(8'd21,  1'b1, 5, 5);
        op8(8'd16,  1'b1, 4, 0);

        // Start while busy is ignored.
        if8.alpha = 8'd100;
        if8.round_nearest = 1'b0;
        if8.start = 1'b1;
        @(posedge clk); #1;
        chk("ign_acc_busy", 32'(if8.busy), 32'd1);
        if8.start = 1'b0;
        @(posedge clk); #1;
        if8.alpha = 8'd9;
        if8.round_nearest = 1'b1;
        if8.start = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0;
        @(posedge clk); #1;
        chk("ign_busy", 32'(if8.busy), 32'd1);
        @(posedge clk); #1;
        chk("ign_valid", 32'(if8.valid), 32'd1);
        chk("ign_root", 32'(if8.root), 32'd10);
        chk("ign_rem", 32'(if8.remainder), 32'd0);
        prev_root8 = 10;

        // Back-to-back start from DONE.
        op8(8'd9, 1'b0, 3, 0);

        // Reset mid-run together with start.
        if8.alpha = 8'd100;
        if8.round_nearest = 1'b0;
        if8.start = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        if8.start = 1'b1;
        if8.alpha = 8'd9;
        @(posedge clk); #1;
        chk("abort_busy", 32'(if8.busy), 32'd0);
        chk("abort_valid", 32'(if8.valid), 32'd0);
        chk("abort_root", 32'(if8.root), 32'd0);
        chk("abort_rem", 32'(if8.remainder), 32'd0);
        rst = 1'b0;
        if8.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("abort_no_valid", 32'(if8.valid), 32'd0);
            chk("abort_idle", 32'(if8.busy), 32'd0);
        end
        prev_root8 = 0;
        op8(8'd49, 1'b0, 7, 0);

        // 16-bit boundaries and a sampled sweep in both modes.
        op16(65535, 1'b0);
        op16(65535, 1'b1);
        op16(0, 1'b1);
        op16(65025, 1'b1);
        op16(65280, 1'b1);
        op16(65281, 1'b1);
        for (int k = 0; k < 1024; k++) begin
            op16(k * 64 + (k % 64), 1'b0);
            op16(k * 64 + ((k * 7) % 64), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
